select_accumulator: RTL and testbench
=====================================

SELECT_ACCUMULATOR -- requirements
Module: select_accumulator

Interface
REQ-001 Parameter Tn, default 4, input channels per group.
REQ-002 Parameter KERNEL_SIZE, default 5, kernel edge; N = Tn*KERNEL_SIZE*KERNEL_SIZE products per beat.
REQ-003 Parameter FEATURE_WIDTH, default 16, width of each unsigned product and of out_data.
REQ-004 Parameter BIAS_WIDTH, default 16, width of unsigned bias.
REQ-005 Parameter ACC_WIDTH, default 32, accumulator width; it SHALL be at least FEATURE_WIDTH + ceil(log2(N)).
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 products_in  input  N*FEATURE_WIDTH  registered products from the select array; element i occupies bits [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH].
REQ-009 in_valid  input  1  products_in is a valid beat this cycle.
REQ-010 first_group  input  1  the beat is the first channel group of an output pixel; qualified by in_valid.
REQ-011 last_group  input  1  the beat is the last channel group of an output pixel; qualified by in_valid.
REQ-012 bias_in  input  BIAS_WIDTH  bias for the pixel; sampled with the beat carrying last_group.
REQ-013 out_data  output  FEATURE_WIDTH  saturated result, acc + bias.
REQ-014 out_valid  output  1  one-cycle pulse marking out_data valid.
REQ-015 out_sat  output  1  out_data was clipped or the accumulator saturated; valid with out_valid.
REQ-016 proto_err  output  1  one-cycle pulse on a protocol violation (REQ-026).

Function
REQ-017 The adder tree SHALL sum all N unsigned products in L = ceil(log2(N)) registered pairwise levels (L = 7 at defaults), each level one cycle.
REQ-018 At an odd-count level the unpaired element SHALL pass through to the next level unchanged; each level widens by 1 bit, with no truncation.
REQ-019 in_valid, first_group, last_group and bias_in SHALL be delayed alongside the tree so they remain aligned with the tree output.
REQ-020 On an aligned beat with first_group=1, acc SHALL load the tree sum; otherwise acc SHALL be set to acc + tree sum.
REQ-021 acc SHALL saturate at 2^ACC_WIDTH-1 and set a sticky sat flag; the flag SHALL clear when a first_group beat is loaded.
REQ-022 On an aligned beat with last_group=1, out_data SHALL equal min(acc_next + bias, 2^FEATURE_WIDTH-1), and out_sat SHALL equal the clip flag OR the sticky sat flag.
REQ-023 Latency: out_valid SHALL rise L+1 edges after the edge that samples in_valid=1 with last_group=1; it SHALL be high for exactly one cycle per last beat.
REQ-024 first_group=1 with last_group=1 on the same beat SHALL produce a single-group result, out_data = min(sum + bias, max).
REQ-025 Control FSM, aligned side, has two states:
- IDLE: no pixel open.
- ACCUM: pixel open.
- IDLE -> ACCUM on a valid first beat without last.
- ACCUM -> IDLE on a valid last beat.
- A first+last beat stays in IDLE.
REQ-026 Protocol violations SHALL pulse proto_err for one cycle:
- Valid beat without first_group in IDLE: the beat SHALL be treated as first.
- first_group in ACCUM: the open pixel is discarded and the new beat loads acc.
REQ-027 Beats with in_valid=0 SHALL not change acc or the FSM; gaps between beats of one pixel are allowed.
REQ-028 Full throughput: one beat per cycle SHALL be accepted indefinitely, and back-to-back pixels SHALL produce back-to-back out_valid pulses.
REQ-029 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-030 rst=1 SHALL immediately clear all pipeline registers, the valid/flag delay lines, acc and sat, and set the FSM to IDLE.
REQ-031 During reset, out_data=0, out_valid=0, out_sat=0 and proto_err=0.
REQ-032 In-flight beats at reset SHALL be dropped; no out_valid SHALL appear from pre-reset beats.

Verification (defaults, N=100, L=7)
REQ-033 Single group: all products=1, bias=5, first=last=1, one beat -> out_valid 8 edges later, out_data=105, out_sat=0.
REQ-034 Three groups: products=2, 3, 4 on consecutive beats (first on beat 1, last on beat 3), bias=0 -> out_data=900, one out_valid pulse.
REQ-035 Clip: all products=1000, single group, bias=0 -> sum 100000, out_data=65535, out_sat=1.
REQ-036 Streaming: 20 consecutive single-group beats with product value k=1..20 -> 20 consecutive out_valid pulses with out_data=100*k in order.
REQ-037 Protocol: a valid beat without first in IDLE -> proto_err pulse, result identical to a first beat; a second first mid-pixel -> proto_err and earlier groups excluded.
REQ-038 Reset mid-flight: assert rst 3 cycles after a last beat -> no out_valid afterwards; the next clean pixel is correct.

Source files
------------

// File: rtl/select_accumulator.sv
// select_accumulator
// Sums the N = Tn*KERNEL_SIZE^2 unsigned products of one beat in a
// registered pairwise adder tree. Beats are accumulated into a saturating
// accumulator across the channel groups of an output pixel. On the last
// group, bias is added and the pixel result is emitted, clipped to
// FEATURE_WIDTH bits.
// Pipeline timing:
//   - L tree stages.
//   - 1 accumulate stage.
//   - 1 output stage.
// So out_valid rises L+1 edges after the edge that samples the last beat.
// N must be at least 2.

module select_accumulator #(
    parameter int Tn            = 4,
    parameter int KERNEL_SIZE   = 5,
    parameter int FEATURE_WIDTH = 16,
    parameter int BIAS_WIDTH    = 16,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0]    products_in,
    input  logic                                                   in_valid,
    input  logic                                                   first_group,
    input  logic                                                   last_group,
    input  logic [BIAS_WIDTH-1:0]                                  bias_in,
    output logic [FEATURE_WIDTH-1:0]                               out_data,
    output logic                                                   out_valid,
    output logic                                                   out_sat,
    output logic                                                   proto_err
);

    localparam int N   = Tn * KERNEL_SIZE * KERNEL_SIZE;
    localparam int L   = $clog2(N);
    // Uniform node width: wide enough for the full tree sum, so no level truncates.
    localparam int TW  = FEATURE_WIDTH + L;
    localparam int AW1 = ACC_WIDTH + 1;
    localparam int OW  = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;

    // Number of live nodes at a tree level (level 0 = raw products).
    function automatic int lvl_cnt(input int lvl);
        return (N + (1 << lvl) - 1) >> lvl;
    endfunction

    // ------------------------------------------------------------------
    // Adder tree.
    // Level 0 is the unpacked input.
    // Each later level is registered and pairs adjacent nodes.
    // An odd leftover node passes through to the next level unchanged.
    // ------------------------------------------------------------------
    generate
        for (genvar l = 0; l <= L; l++) begin : g_lvl
            localparam int CNT = lvl_cnt(l);
            logic [TW-1:0] w_node [0:CNT-1];

            if (l == 0) begin : g_in
                for (genvar j = 0; j < CNT; j++) begin : g_leaf
                    assign w_node[j] = TW'(products_in[j*FEATURE_WIDTH +: FEATURE_WIDTH]);
                end
            end else begin : g_add
                localparam int PCNT = lvl_cnt(l - 1);
                for (genvar j = 0; j < CNT; j++) begin : g_node
                    logic [TW-1:0] r_node;
                    if (2*j + 1 < PCNT) begin : g_pair
                        // Register the sum of two nodes from the previous level.
                        always_ff @(posedge clk or posedge rst) begin
                            if (rst) begin
                                r_node <= '0;
                            end else begin
                                r_node <= g_lvl[l-1].w_node[2*j] + g_lvl[l-1].w_node[2*j+1];
                            end
                        end
                    end else begin : g_pass
                        // Register the unpaired node unchanged.
                        always_ff @(posedge clk or posedge rst) begin
                            if (rst) begin
                                r_node <= '0;
                            end else begin
                                r_node <= g_lvl[l-1].w_node[2*j];
                            end
                        end
                    end
                    assign w_node[j] = r_node;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control delay lines.
    // These keep beat qualifiers and bias aligned with the tree output.
    // ------------------------------------------------------------------
    logic [L-1:0]          r_vld_d;
    logic [L-1:0]          r_first_d;
    logic [L-1:0]          r_last_d;
    logic [BIAS_WIDTH-1:0] r_bias_d [0:L-1];

    // Shift the beat qualifiers and bias one level per cycle, matching the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_d   <= '0;
            r_first_d <= '0;
            r_last_d  <= '0;
            for (int k = 0; k < L; k++) begin
                r_bias_d[k] <= '0;
            end
        end else begin
            r_vld_d[0]   <= in_valid;
            r_first_d[0] <= in_valid & first_group;
            r_last_d[0]  <= in_valid & last_group;
            r_bias_d[0]  <= bias_in;
            for (int k = 1; k < L; k++) begin
                r_vld_d[k]   <= r_vld_d[k-1];
                r_first_d[k] <= r_first_d[k-1];
                r_last_d[k]  <= r_last_d[k-1];
                r_bias_d[k]  <= r_bias_d[k-1];
            end
        end
    end

    logic                  w_vld;
    logic                  w_first;
    logic                  w_last;
    logic [BIAS_WIDTH-1:0] w_bias;
    logic [TW-1:0]         w_sum;

    assign w_vld   = r_vld_d[L-1];
    assign w_first = r_first_d[L-1];
    assign w_last  = r_last_d[L-1];
    assign w_bias  = r_bias_d[L-1];
    assign w_sum   = g_lvl[L].w_node[0];

    // ------------------------------------------------------------------
    // Pixel FSM, evaluated on the aligned side of the tree.
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_load;
    logic   w_proto;

    // Next state, plus whether this beat restarts the accumulator or violates protocol.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_proto      = 1'b0;
        if (w_vld) begin
            case (r_state)
                ST_IDLE: begin
                    // A beat arriving with no pixel open always starts a pixel.
                    w_load       = 1'b1;
                    w_proto      = ~w_first;
                    w_state_next = w_last ? ST_IDLE : ST_ACCUM;
                end
                ST_ACCUM: begin
                    // A first mid-pixel drops the open pixel and restarts.
                    w_load       = w_first;
                    w_proto      = w_first;
                    w_state_next = w_last ? ST_IDLE : ST_ACCUM;
                end
                default: begin
                    w_load       = 1'b1;
                    w_proto      = 1'b0;
                    w_state_next = ST_IDLE;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // ------------------------------------------------------------------
    // Saturating accumulator.
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sat;
    logic [ACC_WIDTH-1:0] w_acc_base;
    logic [AW1-1:0]       w_acc_wide;
    logic                 w_acc_ovf;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_sat_next;

    assign w_acc_base = w_load ? '0 : r_acc;
    assign w_acc_wide = {1'b0, w_acc_base} + AW1'(w_sum);
    assign w_acc_ovf  = w_acc_wide[ACC_WIDTH];
    assign w_acc_next = w_acc_ovf ? '1 : w_acc_wide[ACC_WIDTH-1:0];
    assign w_sat_next = (w_load ? 1'b0 : r_sat) | w_acc_ovf;

    logic                  r_emit;
    logic [BIAS_WIDTH-1:0] r_emit_bias;
    logic                  r_proto_a;

    // FSM state, accumulator and the request to emit a pixel on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_emit      <= 1'b0;
            r_emit_bias <= '0;
            r_proto_a   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_emit      <= w_vld & w_last;
            r_emit_bias <= w_bias;
            r_proto_a   <= w_proto;
            if (w_vld) begin
                r_acc <= w_acc_next;
                r_sat <= w_sat_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: bias add and clip to FEATURE_WIDTH.
    // ------------------------------------------------------------------
    logic [OW-1:0]            w_out_wide;
    logic                     w_clip;
    logic [FEATURE_WIDTH-1:0] w_out_clipped;

    assign w_out_wide    = OW'(r_acc) + OW'(r_emit_bias);
    assign w_clip        = |w_out_wide[OW-1:FEATURE_WIDTH];
    assign w_out_clipped = w_clip ? '1 : w_out_wide[FEATURE_WIDTH-1:0];

    logic [FEATURE_WIDTH-1:0] r_out_data;
    logic                     r_out_valid;
    logic                     r_out_sat;
    logic                     r_proto_err;

    // Output registers. out_data holds its last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_out_valid <= r_emit;
            r_proto_err <= r_proto_a;
            if (r_emit) begin
                r_out_data <= w_out_clipped;
                r_out_sat  <= w_clip | r_sat;
            end else begin
                r_out_sat  <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_select_accumulator.sv
// Bench for select_accumulator (default parameters, N=100, L=7).
// The pixel model is applied per beat. It predicts, per clock cycle, the
// expected out_valid, out_data, out_sat and proto_err, and a negedge
// monitor compares them every cycle. Directed tables and sequences also
// check the captured results against hand-computed constants.

module tb_select_accumulator;

    localparam int TN  = 4;
    localparam int KS  = 5;
    localparam int FW  = 16;
    localparam int BW  = 16;
    localparam int AW  = 32;
    localparam int N   = TN * KS * KS;
    localparam int L   = 7;
    // A beat driven just after edge k is sampled at edge k+1.
    // Its result appears at edge k+1+(L+1).
    localparam int LAT = L + 2;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*FW-1:0]   products_in = '0;
    logic              in_valid = 1'b0;
    logic              first_group = 1'b0;
    logic              last_group = 1'b0;
    logic [BW-1:0]     bias_in = '0;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic              out_sat;
    logic              proto_err;

    select_accumulator #(
        .Tn(TN), .KERNEL_SIZE(KS), .FEATURE_WIDTH(FW), .BIAS_WIDTH(BW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .products_in(products_in), .in_valid(in_valid),
        .first_group(first_group), .last_group(last_group), .bias_in(bias_in),
        .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs, indexed by cycle.
    bit          exp_v [MAXC];
    int unsigned exp_d [MAXC];
    bit          exp_s [MAXC];
    bit          exp_p [MAXC];
    int unsigned exp_last = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed pulses, for the directed checks.
    int unsigned obs_d [$];
    bit          obs_s [$];
    int          obs_c [$];
    int          obs_proto = 0;
    int          last_beat_cyc = 0;

    // Reference model state for the open pixel.
    bit     m_open = 1'b0;
    longint m_acc  = 0;
    bit     m_sat  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, plus capture of output pulses.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (exp_v[cyc]) exp_last = exp_d[cyc];
            check("out_valid", out_valid, exp_v[cyc]);
            check("out_data", out_data, exp_last);
            check("proto_err", proto_err, exp_p[cyc]);
            if (exp_v[cyc]) check("out_sat", out_sat, exp_s[cyc]);
        end
        if (out_valid) begin
            obs_d.push_back(out_data);
            obs_s.push_back(out_sat);
            obs_c.push_back(cyc);
        end
        if (proto_err) obs_proto++;
    end

    // Apply the pixel rules to one valid beat and schedule its effects.
    task automatic model_beat(input bit f, input bit l, input int unsigned b);
        longint sum;
        longint r;
        bit     proto;
        bit     start;
        int     tgt;
        sum = 0;
        for (int i = 0; i < N; i++) sum += products_in[i*FW +: FW];
        proto = (!m_open && !f) || (m_open && f);
        start = !m_open || f;
        if (start) begin
            m_acc = sum;
            m_sat = 1'b0;
        end else begin
            m_acc = m_acc + sum;
        end
        if (m_acc > 64'd4294967295) begin
            m_acc = 64'd4294967295;
            m_sat = 1'b1;
        end
        tgt = cyc + LAT;
        if (l) begin
            r = m_acc + b;
            if (tgt < MAXC) begin
                exp_v[tgt] = 1'b1;
                exp_d[tgt] = (r > 65535) ? 65535 : int'(r);
                exp_s[tgt] = (r > 65535) || m_sat;
            end
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
        if (proto && tgt < MAXC) exp_p[tgt] = 1'b1;
    endtask

    // Drive one cycle of inputs.
    // If rmax is nonzero, each product is random in 0..rmax; otherwise every product is pval.
    task automatic beat(input bit v, input bit f, input bit l, input int unsigned b,
                        input int unsigned pval, input int unsigned rmax);
        @(posedge clk);
        #1;
        in_valid    = v;
        first_group = f;
        last_group  = l;
        bias_in     = BW'(b);
        for (int i = 0; i < N; i++) begin
            products_in[i*FW +: FW] = (rmax == 0) ? FW'(pval) : FW'($urandom_range(rmax, 0));
        end
        last_beat_cyc = cyc;
        if (v) model_beat(f, l, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        first_group = 1'b0;
        last_group = 1'b0;
        for (int i = cyc; i < MAXC; i++) begin
            exp_v[i] = 1'b0;
            exp_p[i] = 1'b0;
        end
        exp_last = 0;
        m_open = 1'b0;
        m_acc  = 0;
        m_sat  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_s.delete();
        obs_c.delete();
    endtask

    typedef struct {
        int unsigned val;
        int unsigned bias;
        int unsigned exp_data;
        bit          exp_sat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int p0;

        tbl[0] = '{1,    5,     105,   1'b0};
        tbl[1] = '{1000, 0,     65535, 1'b1};
        tbl[2] = '{655,  0,     65500, 1'b0};
        tbl[3] = '{655,  35,    65535, 1'b0};
        tbl[4] = '{655,  36,    65535, 1'b1};
        tbl[5] = '{0,    0,     0,     1'b0};
        tbl[6] = '{0,    65535, 65535, 1'b0};
        tbl[7] = '{0,    7,     7,     1'b0};
        tbl[8] = '{600,  5535,  65535, 1'b0};
        tbl[9] = '{600,  5536,  65535, 1'b1};

        // Reset state (also checked every cycle by the monitor).
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        rst = 1'b0;
        idle(2);

        // Single group, with latency.
        clear_obs();
        beat(1'b1, 1'b1, 1'b1, 5, 1, 0);
        bc = last_beat_cyc;
        idle(LAT + 2);
        check("single count", obs_d.size(), 1);
        if (obs_d.size() >= 1) begin
            check("single data", obs_d[0], 105);
            check("single sat", obs_s[0], 0);
            check("single latency", obs_c[0], bc + LAT);
        end

        // Three groups: (2 + 3 + 4) * 100.
        clear_obs();
        beat(1'b1, 1'b1, 1'b0, 0, 2, 0);
        beat(1'b1, 1'b0, 1'b0, 0, 3, 0);
        beat(1'b1, 1'b0, 1'b1, 0, 4, 0);
        idle(LAT + 2);
        check("three count", obs_d.size(), 1);
        if (obs_d.size() >= 1) check("three data", obs_d[0], 900);

        // Table of single-group pixels, streamed back to back.
        clear_obs();
        for (int i = 0; i < 10; i++) beat(1'b1, 1'b1, 1'b1, tbl[i].bias, tbl[i].val, 0);
        idle(LAT + 2);
        check("table count", obs_d.size(), 10);
        for (int i = 0; i < 10 && i < obs_d.size(); i++) begin
            check($sformatf("table[%0d] data", i), obs_d[i], tbl[i].exp_data);
            check($sformatf("table[%0d] sat", i), obs_s[i], tbl[i].exp_sat);
        end

        // Streaming k = 1..20.
        clear_obs();
        for (int k = 1; k <= 20; k++) beat(1'b1, 1'b1, 1'b1, 0, k, 0);
        idle(LAT + 2);
        check("stream count", obs_d.size(), 20);
        for (int k = 0; k < 20 && k < obs_d.size(); k++) begin
            check($sformatf("stream[%0d] data", k), obs_d[k], 100 * (k + 1));
            check($sformatf("stream[%0d] cycle", k), obs_c[k], obs_c[0] + k);
        end

        // Beat without first while idle: flagged, then treated as first.
        clear_obs();
        p0 = obs_proto;
        beat(1'b1, 1'b0, 1'b1, 0, 3, 0);
        idle(LAT + 2);
        check("nofirst proto", obs_proto - p0, 1);
        check("nofirst count", obs_d.size(), 1);
        if (obs_d.size() >= 1) check("nofirst data", obs_d[0], 300);

        // Second first mid-pixel: earlier groups dropped.
        clear_obs();
        p0 = obs_proto;
        beat(1'b1, 1'b1, 1'b0, 0, 2, 0);
        beat(1'b1, 1'b0, 1'b0, 0, 9, 0);
        beat(1'b1, 1'b1, 1'b0, 0, 5, 0);
        beat(1'b1, 1'b0, 1'b1, 0, 1, 0);
        idle(LAT + 2);
        check("refirst proto", obs_proto - p0, 1);
        check("refirst count", obs_d.size(), 1);
        if (obs_d.size() >= 1) check("refirst data", obs_d[0], 600);

        // Gaps inside a pixel; invalid beats carry junk qualifiers.
        clear_obs();
        p0 = obs_proto;
        beat(1'b1, 1'b1, 1'b0, 0, 2, 0);
        beat(1'b0, 1'b1, 1'b1, 9, 50, 0);
        beat(1'b0, 1'b0, 1'b1, 9, 50, 0);
        beat(1'b1, 1'b0, 1'b1, 4, 1, 0);
        idle(LAT + 2);
        check("gap proto", obs_proto - p0, 0);
        check("gap count", obs_d.size(), 1);
        if (obs_d.size() >= 1) check("gap data", obs_d[0], 304);

        // Reset 3 cycles after a last beat drops the in-flight result.
        clear_obs();
        beat(1'b1, 1'b1, 1'b1, 0, 7, 0);
        idle(2);
        do_reset(2);
        idle(LAT + 3);
        check("reset drop count", obs_d.size(), 0);
        beat(1'b1, 1'b1, 1'b1, 1, 4, 0);
        idle(LAT + 2);
        check("post reset count", obs_d.size(), 1);
        if (obs_d.size() >= 1) check("post reset data", obs_d[0], 401);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            beat($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0,
                 $urandom_range(65535, 0), 0, ($urandom_range(7, 0) == 0) ? 65535 : 700);
            if (i == 200) do_reset(1);
        end
        idle(LAT + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
